// File: rtl/paicore_hs_pkg.sv
// Shared types and constants for the PAICORE receive handshake stage.
package paicore_hs_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_HALF = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_REQ,
    ACK_HI
  } rx_state_t;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchronizer for the asynchronous chip request line.
module hs_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/paicore_recv_hs.sv
// Receive handshake stage: four-phase req/ack chip words packed two per
// 64-bit AXI-Stream beat, with tlast/tkeep from the programmed word count.
module paicore_recv_hs #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 2 * WORD_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    recv_enable,
  input  logic [31:0]             recv_len,
  input  logic                    request,
  input  logic [WORD_WIDTH-1:0]   din,
  output logic                    acknowledge,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    o_rx_done,
  output logic                    o_busy
);

  import paicore_hs_pkg::*;

  rx_state_t   state, state_next;
  logic        req_s;
  logic [31:0] len;
  logic [31:0] word_cnt;
  logic        half;
  logic        all_captured;
  logic        final_accepted;

  logic        arm;
  logic        capture;
  logic        done_set;
  logic        beat_hs;
  logic        last_word;
  logic        final_done;

  hs_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (request),
    .q  (req_s)
  );

  assign beat_hs   = m_axis_tvalid && m_axis_tready;
  assign last_word = (word_cnt == (len - 32'd1));
  // The final beat may be accepted before or in the same cycle as the drop of req_s.
  assign final_done = all_captured && (final_accepted || (beat_hs && m_axis_tlast));
  assign o_busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    capture    = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (recv_enable) begin
          if (recv_len != '0) begin
            arm        = 1'b1;
            state_next = WAIT_REQ;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      WAIT_REQ: begin
        if (req_s && !m_axis_tvalid && !all_captured) begin
          capture    = 1'b1;
          state_next = ACK_HI;
        end else if (final_done) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          if (final_done) begin
            done_set   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acknowledge    <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tvalid  <= 1'b0;
      o_rx_done      <= 1'b0;
      len            <= '0;
      word_cnt       <= '0;
      half           <= 1'b0;
      all_captured   <= 1'b0;
      final_accepted <= 1'b0;
    end else begin
      o_rx_done <= done_set;

      if (arm) begin
        len            <= recv_len;
        word_cnt       <= '0;
        half           <= 1'b0;
        all_captured   <= 1'b0;
        final_accepted <= 1'b0;
      end

      if (beat_hs) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast) begin
          final_accepted <= 1'b1;
        end
      end

      // capture only happens with tvalid low, so it never collides with beat_hs
      if (capture) begin
        acknowledge <= 1'b1;
        word_cnt    <= word_cnt + 32'd1;
        half        <= ~half;
        if (last_word) begin
          all_captured <= 1'b1;
        end
        if (half) begin
          m_axis_tdata[DATA_WIDTH-1:WORD_WIDTH] <= din;
          m_axis_tvalid <= 1'b1;
          m_axis_tkeep  <= KEEP_FULL;
          m_axis_tlast  <= last_word;
        end else begin
          m_axis_tdata[WORD_WIDTH-1:0] <= din;
          if (last_word) begin
            m_axis_tdata[DATA_WIDTH-1:WORD_WIDTH] <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tkeep  <= KEEP_HALF;
            m_axis_tlast  <= 1'b1;
          end
        end
      end

      if ((state == ACK_HI) && !req_s) begin
        acknowledge <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paicore_recv_hs.sv
// Directed bench for paicore_recv_hs: chip handshake driver, beat model and per-cycle compare.
module tb_paicore_recv_hs;

  localparam int unsigned SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        recv_enable;
  logic [31:0] recv_len;
  logic        request;
  logic [31:0] din;
  logic        acknowledge;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        done;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] tx_words[$];

  always #5 clk = ~clk;

  paicore_recv_hs #(
    .WORD_WIDTH (32),
    .DATA_WIDTH (64),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .recv_enable  (recv_enable),
    .recv_len     (recv_len),
    .request      (request),
    .din          (din),
    .acknowledge  (acknowledge),
    .m_axis_tdata (tdata),
    .m_axis_tkeep (tkeep),
    .m_axis_tlast (tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .o_rx_done    (done),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected beats: words taken in pairs, odd tail word in the low half.
  function automatic void model_transfer(input int unsigned len);
    beat_t b;
    for (int unsigned i = 0; i < len; i += 2) begin
      b = '0;
      b.data[31:0] = tx_words[i];
      if (i + 1 < len) begin
        b.data[63:32] = tx_words[i+1];
        b.keep        = 8'hFF;
      end else begin
        b.keep = 8'h0F;
      end
      b.last = (i + 2 >= len);
      exp_q.push_back(b);
    end
  endfunction

  // Compare process: beat contents at every handshake, stability under stall.
  initial begin
    beat_t h;
    beat_t e;
    bit    hv;
    hv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (done) done_seen++;
        if (hv) begin
          check("stall_tvalid", tvalid, 1);
          check("stall_tdata", tdata, h.data);
          check("stall_tkeep", tkeep, h.keep);
          check("stall_tlast", tlast, h.last);
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %h, expected none", tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_tdata", tdata, e.data);
            check("beat_tkeep", tkeep, e.keep);
            check("beat_tlast", tlast, e.last);
          end
        end
        hv     = tvalid && !tready;
        h.data = tdata;
        h.keep = tkeep;
        h.last = tlast;
      end
    end
  end

  task automatic wait_ack(input logic v, input string name);
    int n;
    n = 0;
    while (acknowledge !== v) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: acknowledge %b, required %b", name, acknowledge, v);
        return;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    wait_ack(1'b0, "ack_idle");
    din     = w;
    request = 1'b1;
    wait_ack(1'b1, "ack_rise");
    request = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic arm(input logic [31:0] len);
    recv_len    = len;
    recv_enable = 1'b1;
    @(posedge clk);
    #1;
    recv_enable = 1'b0;
    check("busy_armed", busy, 1);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("done_count", done_seen, target);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    recv_enable = 1'b0;
    recv_len    = '0;
    request     = 1'b0;
    din         = '0;
    tready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", acknowledge, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tkeep", tkeep, 0);
    check("rst_tdata", tdata, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four words, two full beats.
    tx_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    model_transfer(4);
    check("model_b0_data", exp_q[0].data, 64'h00000022_00000011);
    check("model_b1_data", exp_q[1].data, 64'h00000044_00000033);
    check("model_b1_last", exp_q[1].last, 1);
    arm(4);
    foreach (tx_words[i]) send_word(tx_words[i]);
    wait_done(1);

    // Three words, odd final beat.
    tx_words = '{32'h11, 32'h22, 32'h33};
    model_transfer(3);
    check("model_odd_data", exp_q[1].data, 64'h00000000_00000033);
    check("model_odd_keep", exp_q[1].keep, 8'h0F);
    arm(3);
    foreach (tx_words[i]) send_word(tx_words[i]);
    wait_done(2);

    // Backpressure: word 3 is not acknowledged while beat 1 is stalled.
    tx_words = '{32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'hA4A4_0004};
    model_transfer(4);
    arm(4);
    tready = 1'b0;
    send_word(tx_words[0]);
    send_word(tx_words[1]);
    check("bp_tvalid", tvalid, 1);
    din     = tx_words[2];
    request = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("bp_ack_low", acknowledge, 0);
    end
    tready = 1'b1;
    wait_ack(1'b1, "bp_ack_rise");
    request = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    send_word(tx_words[3]);
    wait_done(3);

    // Zero length: immediate completion, no beat, no acknowledge.
    recv_len    = '0;
    recv_enable = 1'b1;
    @(posedge clk);
    #1;
    recv_enable = 1'b0;
    check("len0_done", done, 1);
    check("len0_tvalid", tvalid, 0);
    check("len0_ack", acknowledge, 0);
    check("len0_busy", busy, 0);
    wait_done(4);

    // Reset mid-transfer, then a fresh two-word transfer.
    arm(4);
    din     = 32'hDEAD_BEEF;
    request = 1'b1;
    wait_ack(1'b1, "abort_ack_rise");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ack", acknowledge, 0);
    check("abort_tvalid", tvalid, 0);
    check("abort_busy", busy, 0);
    rst     = 1'b0;
    request = 1'b0;
    @(posedge clk);
    #1;
    tx_words = '{32'h0000_0005, 32'h0000_0006};
    model_transfer(2);
    arm(2);
    foreach (tx_words[i]) send_word(tx_words[i]);
    wait_done(5);

    // Synchronizer latency on both request edges.
    tx_words = '{32'h77};
    model_transfer(1);
    arm(1);
    din     = 32'h77;
    request = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acknowledge !== 1'b1 && n < 50);
    check("ack_rise_edges", n, SYNC_STAGES + 1);
    request = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (acknowledge !== 1'b0 && n < 50);
    check("ack_fall_edges", n, SYNC_STAGES + 1);
    wait_done(6);

    check("beats_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
